// File: rtl/multicycle_controller.sv
// Multicycle MIPS-style control FSM: sequences fetch/decode/execute/memory/writeback.
// Define MULTICYCLE_IMM_LOGIC_EN to decode ANDI/ORI/XORI/SLTI into the immediate path.
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       IorD,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       ALUSrcA,
    output logic       ExtSel,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic [3:0] state,
    output logic       illegal
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_IEX     = 4'd8,
        S_IWB     = 4'd9,
        S_BRANCH  = 4'd10,
        S_JUMP    = 4'd11,
        S_ERROR   = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] FN_JR    = 6'b001000;

    state_t r_state;
    state_t w_next;
    logic   w_is_imm;
    logic   w_ext_op;

`ifdef MULTICYCLE_IMM_LOGIC_EN
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_XORI = 6'b001110;
    localparam logic [5:0] OP_SLTI = 6'b001010;

    assign w_is_imm = (opcode == OP_ADDI) || (opcode == OP_ANDI) || (opcode == OP_ORI) ||
                      (opcode == OP_XORI) || (opcode == OP_SLTI);
    assign w_ext_op = (opcode == OP_ANDI) || (opcode == OP_ORI) || (opcode == OP_XORI);
`else
    assign w_is_imm = (opcode == OP_ADDI);
    assign w_ext_op = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        IorD     = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        RegWrite = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        ALUSrcA  = 1'b0;
        ExtSel   = 1'b0;
        ALUSrcB  = 2'b00;
        ALUOp    = 2'b00;
        PCSrc    = 2'b00;
        illegal  = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_req = 1'b1;
                ALUSrcB = 2'b01;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    w_next  = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                if ((opcode == OP_LW) || (opcode == OP_SW))        w_next = S_MEMADR;
                else if (opcode == OP_RTYPE)                       w_next = S_RTYPEEX;
                else if ((opcode == OP_BEQ) || (opcode == OP_BNE)) w_next = S_BRANCH;
                else if (opcode == OP_J)                           w_next = S_JUMP;
                else if (w_is_imm)                                 w_next = S_IEX;
                else                                               w_next = S_ERROR;
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                w_next  = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                w_next   = S_FETCH;
            end
            S_MEMWR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) w_next = S_FETCH;
            end
            S_RTYPEEX: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                if (funct == FN_JR) begin
                    PCWrite = 1'b1;
                    PCSrc   = 2'b11;
                    w_next  = S_FETCH;
                end else begin
                    w_next  = S_RTYPEWB;
                end
            end
            S_RTYPEWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                w_next   = S_FETCH;
            end
            S_IEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = 2'b11;
                ExtSel  = w_ext_op;
                w_next  = S_IWB;
            end
            S_IWB: begin
                RegWrite = 1'b1;
                ExtSel   = w_ext_op;
                w_next   = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b01;
                PCSrc   = 2'b01;
                PCWrite = (opcode == OP_BNE) ? ~Zero : Zero;
                w_next  = S_FETCH;
            end
            S_JUMP: begin
                PCWrite = 1'b1;
                PCSrc   = 2'b10;
                w_next  = S_FETCH;
            end
            S_ERROR: begin
                illegal = 1'b1;
            end
            default: w_next = S_ERROR;
        endcase
        // State is already FETCH under async reset; only the side-effecting strobes need masking.
        if (reset) begin
            mem_req  = 1'b0;
            mem_we   = 1'b0;
            IRWrite  = 1'b0;
            PCWrite  = 1'b0;
            RegWrite = 1'b0;
        end
    end

    assign state = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized self-checking bench for multicycle_controller against a per-instruction
// state-trace model; honours MULTICYCLE_IMM_LOGIC_EN for the immediate-opcode expectations.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode, funct;
    logic       Zero, mem_ready;
    logic       mem_req, mem_we, IorD, IRWrite, PCWrite, RegWrite, RegDst, MemtoReg;
    logic       ALUSrcA, ExtSel, illegal;
    logic [1:0] ALUSrcB, ALUOp, PCSrc;
    logic [3:0] state;

    typedef struct packed {
        logic       mem_req, mem_we, IorD, IRWrite, PCWrite, RegWrite, RegDst, MemtoReg;
        logic       ALUSrcA, ExtSel;
        logic [1:0] ALUSrcB, ALUOp, PCSrc;
        logic       illegal;
    } outs_t;

    int n_vec = 0;
    int n_bad = 0;
    int q_st[$];
    bit q_mr[$];

    multicycle_controller dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .Zero(Zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .IorD(IorD),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ExtSel(ExtSel), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .PCSrc(PCSrc), .state(state), .illegal(illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timed out");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h (op=%b fn=%b)", tag, $time, got, exp, opcode, funct);
        end
    endtask

    function automatic bit imm_legal(input logic [5:0] op);
`ifdef MULTICYCLE_IMM_LOGIC_EN
        return op inside {6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001010};
`else
        return op == 6'b001000;
`endif
    endfunction

    function automatic bit ext_of(input logic [5:0] op);
`ifdef MULTICYCLE_IMM_LOGIC_EN
        return op inside {6'b001100, 6'b001101, 6'b001110};
`else
        return (op == 6'b111111) && (op != 6'b111111);
`endif
    endfunction

    // Expected control word for a given state code, straight from the per-state table.
    function automatic outs_t model(input int st, input bit mr, input bit rst,
                                    input logic [5:0] op, input logic [5:0] fn, input bit z);
        outs_t o = '0;
        if (rst) begin
            o.ALUSrcB = 2'b01;
            return o;
        end
        case (st)
            0:  begin o.mem_req = 1; o.ALUSrcB = 2'b01; o.IRWrite = mr; o.PCWrite = mr; end
            1:  o.ALUSrcB = 2'b11;
            2:  begin o.ALUSrcA = 1; o.ALUSrcB = 2'b10; end
            3:  begin o.mem_req = 1; o.IorD = 1; end
            4:  begin o.RegWrite = 1; o.MemtoReg = 1; end
            5:  begin o.mem_req = 1; o.mem_we = 1; o.IorD = 1; end
            6:  begin
                    o.ALUSrcA = 1; o.ALUOp = 2'b10;
                    if (fn == 6'b001000) begin o.PCWrite = 1; o.PCSrc = 2'b11; end
                end
            7:  begin o.RegWrite = 1; o.RegDst = 1; end
            8:  begin o.ALUSrcA = 1; o.ALUSrcB = 2'b10; o.ALUOp = 2'b11; o.ExtSel = ext_of(op); end
            9:  begin o.RegWrite = 1; o.ExtSel = ext_of(op); end
            10: begin
                    o.ALUSrcA = 1; o.ALUOp = 2'b01; o.PCSrc = 2'b01;
                    o.PCWrite = (op == 6'b000100) ? z : ~z;
                end
            11: begin o.PCWrite = 1; o.PCSrc = 2'b10; end
            15: o.illegal = 1;
            default: o = '0;
        endcase
        return o;
    endfunction

    function automatic outs_t observed();
        return {mem_req, mem_we, IorD, IRWrite, PCWrite, RegWrite, RegDst, MemtoReg,
                ALUSrcA, ExtSel, ALUSrcB, ALUOp, PCSrc, illegal};
    endfunction

    task automatic push(input int st, input bit mr);
        q_st.push_back(st);
        q_mr.push_back(mr);
    endtask

    // Called at a negedge; returns at a negedge with reset released.
    task automatic reset_pulse();
        #2;
        reset     = 1'b1;
        mem_ready = 1'($urandom);
        #1;
        check_val("rst_state", 32'(state), 32'd0);
        check_val("rst_outs", 32'(observed()), 32'(model(0, mem_ready, 1'b1, opcode, funct, Zero)));
        @(negedge clk);
        check_val("rst_hold_state", 32'(state), 32'd0);
        reset = 1'b0;
    endtask

    // zsel: 0/1 force Zero, 2 random. abort_after>0 resets after that many cycles.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int wf,
                             input int wm, input int zsel, input int abort_after);
        bit err = 1'b0;
        int n;
        q_st.delete();
        q_mr.delete();
        opcode = op;
        funct  = fn;
        repeat (wf) push(0, 1'b0);
        push(0, 1'b1);
        push(1, 1'($urandom));
        if (op == 6'b100011) begin
            push(2, 1'($urandom));
            repeat (wm) push(3, 1'b0);
            push(3, 1'b1);
            push(4, 1'($urandom));
        end else if (op == 6'b101011) begin
            push(2, 1'($urandom));
            repeat (wm) push(5, 1'b0);
            push(5, 1'b1);
        end else if (op == 6'b000000) begin
            push(6, 1'($urandom));
            if (fn != 6'b001000) push(7, 1'($urandom));
        end else if (op == 6'b000100 || op == 6'b000101) begin
            push(10, 1'($urandom));
        end else if (op == 6'b000010) begin
            push(11, 1'($urandom));
        end else if (imm_legal(op)) begin
            push(8, 1'($urandom));
            push(9, 1'($urandom));
        end else begin
            err = 1'b1;
            repeat (10) push(15, 1'($urandom));
        end
        n = q_st.size();
        if (abort_after > 0 && abort_after < n) n = abort_after;
        for (int i = 0; i < n; i++) begin
            mem_ready = q_mr[i];
            Zero      = (zsel == 2) ? 1'($urandom) : zsel[0];
            #1;
            check_val("state", 32'(state), 32'(q_st[i]));
            check_val("outs", 32'(observed()), 32'(model(q_st[i], mem_ready, 1'b0, op, fn, Zero)));
            @(negedge clk);
        end
        if (err || abort_after > 0) reset_pulse();
    endtask

    logic [5:0] ops [12] = '{6'b100011, 6'b101011, 6'b000000, 6'b000000, 6'b000100, 6'b000101,
                             6'b000010, 6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b111111};

    initial begin
        reset     = 1'b1;
        opcode    = '0;
        funct     = '0;
        Zero      = 1'b0;
        mem_ready = 1'b1;
        #1;
        check_val("init_state", 32'(state), 32'd0);
        check_val("init_outs", 32'(observed()), 32'(model(0, 1'b1, 1'b1, opcode, funct, Zero)));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        run_instr(6'b000000, 6'b100000, 0, 0, 2, 0);   // add
        run_instr(6'b100011, 6'b000000, 0, 2, 2, 0);   // lw, 2 wait cycles
        run_instr(6'b101011, 6'b000000, 1, 0, 2, 0);   // sw, fetch stall
        run_instr(6'b000100, 6'b000000, 0, 0, 1, 0);   // beq taken
        run_instr(6'b000101, 6'b000000, 0, 0, 1, 0);   // bne not taken
        run_instr(6'b000101, 6'b000000, 0, 0, 0, 0);   // bne taken
        run_instr(6'b000000, 6'b001000, 0, 0, 2, 0);   // jr
        run_instr(6'b000010, 6'b000000, 0, 0, 2, 0);   // j
        run_instr(6'b001000, 6'b000000, 0, 0, 2, 0);   // addi
        run_instr(6'b001101, 6'b000000, 0, 0, 2, 0);   // ori
        run_instr(6'b111111, 6'b000000, 0, 0, 2, 0);   // illegal, then reset
        run_instr(6'b101011, 6'b000000, 0, 6, 2, 6);   // reset during stalled MEMWR
        run_instr(6'b100011, 6'b000000, 0, 0, 2, 0);

        for (int k = 0; k < 80; k++) begin
            logic [5:0] op;
            logic [5:0] fn;
            op = ops[$urandom_range(0, 11)];
            fn = ($urandom_range(0, 3) == 0) ? 6'b001000 : 6'($urandom);
            run_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 3), 2,
                      ($urandom_range(0, 9) == 0) ? $urandom_range(1, 4) : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
